// File: rtl/ibuf_loader.sv
// ibuf_loader: upstream feeder for the four column input buffers of the MAC array.
// On an accepted START it reads one N x N row-major 8-bit matrix from the operand
// SRAM and loads A[r][c] into column buffer c, slot r. It then issues a
// column-skewed ENDown burst and finishes with a one-cycle DONE pulse.
// Phases: IDLE -> LOAD (N*N reads) -> FLUSH (2) -> DRAIN (2N-1) -> FIN (1).
// All outputs come straight from registers.
module ibuf_loader #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] BASE,
  output logic          MEM_RE,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [N-1:0]  WriteEN,
  output logic [1:0]    ICOL,
  output logic [DW-1:0] IWord8,
  output logic [N-1:0]  ENDown,
  output logic          BUSY,
  output logic          DONE
);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  // Last element index of the load, last flush cycle, last drain step.
  localparam logic [3:0] LP_K_LAST     = 4'(N * N - 1);
  localparam logic [3:0] LP_FLUSH_LAST = 4'd1;
  localparam logic [3:0] LP_J_LAST     = 4'(2 * N - 2);

  // One-hot column select for the load strobe.
  function automatic logic [N-1:0] f_onehot(input logic [1:0] idx);
    logic [N-1:0] v;
    v      = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Skewed emit window: column c is enabled for drain steps c .. c+N-1.
  function automatic logic [N-1:0] f_skew_window(input logic [3:0] j);
    logic [N-1:0] v;
    v = {N{1'b0}};
    for (int c = 0; c < N; c++) begin
      v[c] = (int'(j) >= c) && (int'(j) <= c + N - 1);
    end
    return v;
  endfunction

  // Control state
  logic [2:0]    r_state;
  logic [3:0]    r_cnt;      // element index k in LOAD, flush step, drain step j
  logic [AW-1:0] r_base_q;

  // Read-return pipeline: marks the cycle in which MEM_RDATA is valid and
  // remembers which element index it belongs to.
  logic          r_p1_vld;
  logic [3:0]    r_p1_k;

  // Output registers
  logic          r_mem_re;
  logic [AW-1:0] r_mem_addr;
  logic [N-1:0]  r_wen;
  logic [1:0]    r_icol;
  logic [DW-1:0] r_word;
  logic [N-1:0]  r_endown;
  logic          r_busy;
  logic          r_done;

  // Next-state values
  logic [2:0]    w_state_nxt;
  logic [3:0]    w_cnt_nxt;
  logic [3:0]    w_cnt_inc;
  logic [AW-1:0] w_base_nxt;
  logic          w_re_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [N-1:0]  w_endown_nxt;
  logic          w_done_nxt;
  logic          w_busy_nxt;
  logic [N-1:0]  w_wen_nxt;
  logic [1:0]    w_icol_nxt;
  logic [DW-1:0] w_word_nxt;

  assign w_cnt_inc  = r_cnt + 4'd1;
  // BUSY covers every non-idle cycle, including the FIN cycle carrying DONE.
  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  // Sequencer: next state, counter, read request and drain strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_base_nxt   = r_base_q;
    w_re_nxt     = 1'b0;
    w_addr_nxt   = {AW{1'b0}};
    w_endown_nxt = {N{1'b0}};
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt = S_LOAD;
          w_base_nxt  = BASE;
          w_cnt_nxt   = 4'd0;
          w_re_nxt    = 1'b1;
          w_addr_nxt  = BASE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (r_cnt == LP_K_LAST) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_re_nxt   = 1'b1;
          // Modulo 2^AW: the address is allowed to wrap past the top of memory.
          w_addr_nxt = r_base_q + {{(AW-4){1'b0}}, w_cnt_inc};
        end
      end
      S_FLUSH: begin
        if (r_cnt == LP_FLUSH_LAST) begin
          w_state_nxt  = S_DRAIN;
          w_cnt_nxt    = 4'd0;
          w_endown_nxt = f_skew_window(4'd0);
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_DRAIN: begin
        if (r_cnt == LP_J_LAST) begin
          w_state_nxt = S_FIN;
          w_cnt_nxt   = 4'd0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt    = w_cnt_inc;
          w_endown_nxt = f_skew_window(w_cnt_inc);
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Load strobe generation: one cycle after read data returns, steer it to
  // column (k mod N), slot (k / N); otherwise the load bus idles at zero.
  always_comb begin
    w_wen_nxt  = {N{1'b0}};
    w_icol_nxt = 2'd0;
    w_word_nxt = {DW{1'b0}};
    if (r_p1_vld) begin
      w_wen_nxt  = f_onehot(r_p1_k[1:0]);
      w_icol_nxt = r_p1_k[3:2];
      w_word_nxt = MEM_RDATA;
    end else begin
      w_wen_nxt  = {N{1'b0}};
      w_icol_nxt = 2'd0;
      w_word_nxt = {DW{1'b0}};
    end
  end

  // State, pipeline and output registers with synchronous reset; reset aborts
  // any transfer in flight, including reads whose data has not yet been loaded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_base_q   <= {AW{1'b0}};
      r_p1_vld   <= 1'b0;
      r_p1_k     <= 4'd0;
      r_mem_re   <= 1'b0;
      r_mem_addr <= {AW{1'b0}};
      r_wen      <= {N{1'b0}};
      r_icol     <= 2'd0;
      r_word     <= {DW{1'b0}};
      r_endown   <= {N{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_base_q   <= w_base_nxt;
      r_p1_vld   <= r_mem_re;
      r_p1_k     <= r_cnt;
      r_mem_re   <= w_re_nxt;
      r_mem_addr <= w_addr_nxt;
      r_wen      <= w_wen_nxt;
      r_icol     <= w_icol_nxt;
      r_word     <= w_word_nxt;
      r_endown   <= w_endown_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign MEM_RE   = r_mem_re;
  assign MEM_ADDR = r_mem_addr;
  assign WriteEN  = r_wen;
  assign ICOL     = r_icol;
  assign IWord8   = r_word;
  assign ENDown   = r_endown;
  assign BUSY     = r_busy;
  assign DONE     = r_done;

endmodule

// File: doc/ibuf_loader.md
Name: ibuf_loader

Overview:
- Upstream feeder for the four column input buffers of the MAC array.
- On START, reads one N x N 8-bit matrix (row-major) from the operand SRAM and loads element A[r][c] into column buffer c, slot r.
- Then issues a column-skewed ENDown burst so the buffers stream data into the PE rows diagonally.
- Signals completion with a one-cycle DONE pulse.

Parameters:
- N, 4, matrix dimension, equal to the number of column buffers; fixed at 4 in this revision.
- DW, 8, element width.
- AW, 10, SRAM address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- BASE  in  AW  matrix base address; captured when START is accepted.
- MEM_RE  out  1  SRAM read enable, registered.
- MEM_ADDR  out  AW  SRAM read address, registered.
- MEM_RDATA  in  DW  SRAM read data, valid exactly one cycle after MEM_RE.
- WriteEN  out  N  one-hot load strobe, bit c drives column buffer c.
- ICOL  out  2  slot index (row r) for the load, shared by all buffers.
- IWord8  out  DW  load data, shared by all buffers.
- ENDown  out  N  per-column shift/emit enable.
- BUSY  out  1  high from START acceptance through the DONE cycle.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset
  - Synchronous: every output is 0, state is IDLE, all counters and BASE_q are cleared.
  - Reset asserted mid-operation aborts immediately; the next cycle shows all outputs 0.
  - No partial DONE is ever produced.
- FSM: IDLE -> LOAD -> FLUSH -> DRAIN -> FIN -> IDLE. All outputs are registered.
- IDLE
  - START=1 captures BASE into BASE_q and moves to LOAD.
  - START is ignored in every other state; there is no queueing.
- LOAD (N*N = 16 cycles)
  - MEM_RE=1 and MEM_ADDR = BASE_q + k for k = 0..15.
  - Address arithmetic is modulo 2^AW, so wrap-around is permitted.
  - Read pipeline: a read issued at cycle t returns MEM_RDATA at t+1. One cycle after that (t+2), the block drives:
    - WriteEN = one-hot(k mod N)
    - ICOL = k / N
    - IWord8 = registered data
  - Exactly one WriteEN bit is high per write cycle, and 16 writes occur in total.
- FLUSH (2 cycles)
  - MEM_RE=0.
  - The last two pipelined writes complete.
- DRAIN (2N-1 = 7 cycles, j = 0..6)
  - ENDown[c] = 1 iff c <= j <= c+N-1, so each column gets N consecutive cycles, offset by c.
  - WriteEN=0 throughout; a WriteEN bit and the matching ENDown bit are never high in the same cycle.
- FIN (1 cycle)
  - DONE=1, BUSY=1, all strobes 0.
  - Next state is IDLE.
- Cycle timing, with START sampled at edge 0 and cycle 1 being the first cycle in LOAD:
  - MEM_RE high in cycles 1..16.
  - WriteEN active in cycles 3..18.
  - ENDown[0] high in cycles 19..22, ENDown[3] high in cycles 22..25.
  - DONE in cycle 26; a new START is accepted from cycle 27.
  - BUSY high in cycles 1..26.
- Inactive values: when not loading, IWord8 and ICOL hold 0.

Test Plan:
- Reset, then START with BASE=0x000, where memory[a] = a+1 -> 16 reads at addresses 0..15 in cycles 1..16. Cycle 3: WriteEN=0001, ICOL=0, IWord8=0x01. Cycle 18: WriteEN=1000, ICOL=3, IWord8=0x10. DONE in cycle 26 only.
- Same run with four buffer instances attached -> column 2 emits OD sequence 0x03, 0x07, 0x0B, 0x0F, appearing 2 cycles after column 0's first OD. ENDown exactly matches the skew windows.
- BASE=0x3FC (AW=10) -> MEM_ADDR sequence 0x3FC, 0x3FD, 0x3FE, 0x3FF, 0x000 .. 0x00B (wrap-around). The data mapping is unchanged.
- START pulsed in cycles 5 and 26 -> both ignored: only one DONE pulse and no extra reads. A START in cycle 27 begins a new load, with MEM_RE high from cycle 28.
- RST asserted in cycle 10 of LOAD for one cycle -> all outputs 0 from cycle 11, BUSY=0, no DONE. A subsequent START behaves exactly like a fresh run.
- Assertions over all runs:
  - WriteEN is one-hot or zero.
  - (WriteEN & ENDown) == 0.
  - DONE high implies BUSY high.
  - popcount(ENDown) <= N.
